exception_ctrl: RTL and testbench
=================================

// Module: exception_ctrl
// PURPOSE
//  Downstream consumer of the undefined/aborted-instruction tracker. Collects exception
//  requests: prefetch abort (tracker InstrExecuting), undefined, SWI, data abort, IRQ, FIQ.
//  Prioritises them and runs a short FSM that flushes the pipe, saves LR/SPSR, switches
//  mode and redirects fetch to the exception vector. Sits beside the hazard unit; drives
//  the PC mux and the CPSR/banked-register write controls.
// PARAMETERS
//  HIGH_VECTORS  0  1: vector base 0xFFFF0000; 0: vector base 0x00000000
//  SYNC_STAGES   2  synchroniser depth for asynchronous IRQ/FIQ pins (>=2)
// PORTS
//  clk            in   1   single clock, rising edge
//  reset          in   1   asynchronous, active-high
//  Stall          in   1   pipeline stall; FSM holds state and outputs while high
//  PrefetchAbortE in   1   aborted instruction reached Execute (tracker InstrExecuting)
//  UndefE         in   1   undefined instruction in Execute
//  SWIE           in   1   SWI in Execute
//  DataAbortM     in   1   data abort from MMU, Memory stage
//  IRQ            in   1   interrupt pin, asynchronous, level
//  FIQ            in   1   fast interrupt pin, asynchronous, level
//  CPSRI          in   1   CPSR I bit (1 = IRQ masked)
//  CPSRF          in   1   CPSR F bit (1 = FIQ masked)
//  ExcFlush       out  1   flush D/E/M stages
//  ExcSave        out  1   write LR and SPSR of the target mode
//  ExcMode        out  5   target CPSR mode, valid while ExcSave
//  ExcSetI        out  1   set CPSR I, with ExcSave
//  ExcSetF        out  1   set CPSR F, with ExcSave
//  ExcPCSel       out  1   select ExcVector as next PC
//  ExcVector      out  32  vector address, valid while ExcPCSel
//  ExcBusy        out  1   FSM not IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; synchroniser flops cleared; all outputs 0, ExcVector=0.
//  - IRQ/FIQ pass through SYNC_STAGES flops before use; edge-to-visible latency = SYNC_STAGES.
//  - Effective requests: irq = IRQs & ~CPSRI; fiq = FIQs & ~CPSRF; others are used raw.
//  - Priority, high to low: DataAbortM > fiq > irq > PrefetchAbortE > UndefE > SWIE.
//  - IDLE: if ~Stall and any request, latch the winner into exc_q and go to SAVE.
//    Losing requests are dropped; Execute-stage sources are flushed and refetch later.
//    Level interrupts stay pending and are taken later if still unmasked.
//  - SAVE, 1 cycle: ExcFlush=1, ExcSave=1, ExcMode/ExcSetI/ExcSetF per exc_q.
//    Next state REDIRECT.
//  - REDIRECT, 1 cycle: ExcFlush=1, ExcPCSel=1, ExcVector=base|offset(exc_q).
//    Next state IDLE.
//  - Stall high in SAVE or REDIRECT: state and all outputs held (strobes stay high);
//    the datapath qualifies writes with ~Stall.
//  - Latency: accept at edge T; SAVE cycle T+1; REDIRECT cycle T+2; IDLE again at T+3.
//    Earliest next accept is T+3.
//  - Requests while not IDLE are ignored; the FSM is never re-entered mid-sequence.
//  - Offset/mode table: UND 0x04/11011; SWI 0x08/10011; PABT 0x0C/10111;
//    DABT 0x10/10111; IRQ 0x18/10010; FIQ 0x1C/10001.
//  - ExcSetI=1 for all types; ExcSetF=1 only for FIQ.
//  - reset asserted mid-sequence: return to IDLE at once; no partial strobes after release.
//  - Illegal state encoding: return to IDLE.
// STRUCTURE
//  - leg_exc_pkg: exc_t enum {EXC_NONE,UND,SWI,PABT,DABT,IRQ,FIQ}, exc_state_t enum,
//    functions vec_offset(exc_t) and exc_mode(exc_t), mode constants.
//  - Sub-module irq_sync (#(SYNC_STAGES) flop chain, async reset): one instance for IRQ,
//    one for FIQ.
//  - FSM, priority encoder and output decode live in this module.
// TESTING
//  1 UndefE=1 one cycle in IDLE -> T+1 ExcSave, ExcMode=11011, ExcSetI=1;
//    T+2 ExcPCSel, ExcVector=0x04.
//  2 DataAbortM, PrefetchAbortE, UndefE same cycle -> DABT only:
//    ExcMode=10111, ExcVector=0x10, no second sequence.
//  3 IRQ rises, CPSRI=0, HIGH_VECTORS=1 -> ExcSave 3 cycles after the edge
//    (2 sync + accept), ExcVector=0xFFFF0018. With CPSRI=1 -> no response.
//  4 FIQ and IRQ both high, both unmasked -> FIQ taken: ExcMode=10001, ExcSetF=1, vector 0x1C.
//  5 Stall=1 for 3 cycles during SAVE -> ExcSave held 4 cycles total, then REDIRECT 1 cycle.
//  6 reset pulsed during REDIRECT -> all outputs 0 next cycle; SWIE after release ->
//    normal SWI sequence, vector 0x08.

Source files
------------

// File: rtl/exception_ctrl_pkg.sv
// Shared types, CPSR mode constants and vector/mode lookups
// for the exception controller.
package exception_ctrl_pkg;

    typedef enum logic [2:0] {
        EXC_NONE,
        EXC_UND,
        EXC_SWI,
        EXC_PABT,
        EXC_DABT,
        EXC_IRQ,
        EXC_FIQ
    } exc_t;

    typedef logic [1:0] exc_state_t;

    localparam exc_state_t ST_IDLE     = 2'd0;
    localparam exc_state_t ST_SAVE     = 2'd1;
    localparam exc_state_t ST_REDIRECT = 2'd2;

    localparam logic [4:0] MODE_FIQ = 5'b10001;
    localparam logic [4:0] MODE_IRQ = 5'b10010;
    localparam logic [4:0] MODE_SVC = 5'b10011;
    localparam logic [4:0] MODE_ABT = 5'b10111;
    localparam logic [4:0] MODE_UND = 5'b11011;

    localparam logic [31:0] VEC_BASE_HI = 32'hFFFF_0000;
    localparam logic [31:0] VEC_BASE_LO = 32'h0000_0000;

    function automatic logic [7:0] vec_offset(exc_t e);
        logic [7:0] off;
        unique case (e)
            EXC_UND:  off = 8'h04;
            EXC_SWI:  off = 8'h08;
            EXC_PABT: off = 8'h0C;
            EXC_DABT: off = 8'h10;
            EXC_IRQ:  off = 8'h18;
            EXC_FIQ:  off = 8'h1C;
            default:  off = 8'h00;
        endcase
        return off;
    endfunction

    function automatic logic [4:0] exc_mode(exc_t e);
        logic [4:0] m;
        unique case (e)
            EXC_UND:  m = MODE_UND;
            EXC_SWI:  m = MODE_SVC;
            EXC_PABT: m = MODE_ABT;
            EXC_DABT: m = MODE_ABT;
            EXC_IRQ:  m = MODE_IRQ;
            EXC_FIQ:  m = MODE_FIQ;
            default:  m = 5'b00000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/exception_ctrl_if.sv
// Request/response bundle between the pipeline and the
// exception controller.
interface exception_ctrl_if;

    logic        Stall;
    logic        PrefetchAbortE;
    logic        UndefE;
    logic        SWIE;
    logic        DataAbortM;
    logic        IRQ;
    logic        FIQ;
    logic        CPSRI;
    logic        CPSRF;

    logic        ExcFlush;
    logic        ExcSave;
    logic [4:0]  ExcMode;
    logic        ExcSetI;
    logic        ExcSetF;
    logic        ExcPCSel;
    logic [31:0] ExcVector;
    logic        ExcBusy;

    modport master (
        output Stall, PrefetchAbortE, UndefE, SWIE, DataAbortM,
        output IRQ, FIQ, CPSRI, CPSRF,
        input  ExcFlush, ExcSave, ExcMode, ExcSetI, ExcSetF,
        input  ExcPCSel, ExcVector, ExcBusy
    );

    modport slave (
        input  Stall, PrefetchAbortE, UndefE, SWIE, DataAbortM,
        input  IRQ, FIQ, CPSRI, CPSRF,
        output ExcFlush, ExcSave, ExcMode, ExcSetI, ExcSetF,
        output ExcPCSel, ExcVector, ExcBusy
    );

endinterface

// File: rtl/exception_ctrl_irq_sync.sv
// Multi-flop synchroniser for an asynchronous interrupt pin.
// Pin-to-output latency equals STAGES clock edges.
module exception_ctrl_irq_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr <= '0;
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/exception_ctrl.sv
// Exception controller: prioritises exception requests and runs
// the flush / save / redirect sequence into the vector table.
module exception_ctrl
    import exception_ctrl_pkg::*;
#(
    parameter bit HIGH_VECTORS = 1'b0,
    parameter int SYNC_STAGES  = 2
) (
    input logic              clk,
    input logic              reset,
    exception_ctrl_if.slave  bus
);

    logic       irq_s;
    logic       fiq_s;
    logic       irq;
    logic       fiq;
    exc_t       win;
    exc_t       exc_q;
    exc_state_t state;

    localparam logic [31:0] VEC_BASE =
        HIGH_VECTORS ? VEC_BASE_HI : VEC_BASE_LO;

    exception_ctrl_irq_sync #(.STAGES(SYNC_STAGES)) u_irq_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.IRQ),
        .q     (irq_s)
    );

    exception_ctrl_irq_sync #(.STAGES(SYNC_STAGES)) u_fiq_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.FIQ),
        .q     (fiq_s)
    );

    assign irq = irq_s & ~bus.CPSRI;
    assign fiq = fiq_s & ~bus.CPSRF;

    always_comb begin
        win = EXC_NONE;
        if (bus.DataAbortM)          win = EXC_DABT;
        else if (fiq)                win = EXC_FIQ;
        else if (irq)                win = EXC_IRQ;
        else if (bus.PrefetchAbortE) win = EXC_PABT;
        else if (bus.UndefE)         win = EXC_UND;
        else if (bus.SWIE)           win = EXC_SWI;
    end

    // An unused encoding recovers to IDLE even under stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            exc_q <= EXC_NONE;
        end else if (!bus.Stall || state > ST_REDIRECT) begin
            case (state)
                ST_IDLE: begin
                    if (win != EXC_NONE) begin
                        exc_q <= win;
                        state <= ST_SAVE;
                    end
                end
                ST_SAVE:     state <= ST_REDIRECT;
                ST_REDIRECT: state <= ST_IDLE;
                default:     state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.ExcFlush  = 1'b0;
        bus.ExcSave   = 1'b0;
        bus.ExcMode   = 5'b00000;
        bus.ExcSetI   = 1'b0;
        bus.ExcSetF   = 1'b0;
        bus.ExcPCSel  = 1'b0;
        bus.ExcVector = 32'h0;
        bus.ExcBusy   = (state != ST_IDLE);
        case (state)
            ST_SAVE: begin
                bus.ExcFlush = 1'b1;
                bus.ExcSave  = 1'b1;
                bus.ExcMode  = exc_mode(exc_q);
                bus.ExcSetI  = 1'b1;
                bus.ExcSetF  = (exc_q == EXC_FIQ);
            end
            ST_REDIRECT: begin
                bus.ExcFlush  = 1'b1;
                bus.ExcPCSel  = 1'b1;
                bus.ExcVector = VEC_BASE | {24'h0, vec_offset(exc_q)};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed bench for exception_ctrl: low- and high-vector
// instances share stimulus; expectations are hand-computed.
module tb_exception_ctrl;

    logic clk = 1'b0;
    logic reset;

    logic stall, pabt, und, swi, dabt, irq, fiq, cpsr_i, cpsr_f;

    int n_cmp = 0;
    int n_bad = 0;

    exception_ctrl_if bus_lo ();
    exception_ctrl_if bus_hi ();

    assign bus_lo.Stall          = stall;
    assign bus_lo.PrefetchAbortE = pabt;
    assign bus_lo.UndefE         = und;
    assign bus_lo.SWIE           = swi;
    assign bus_lo.DataAbortM     = dabt;
    assign bus_lo.IRQ            = irq;
    assign bus_lo.FIQ            = fiq;
    assign bus_lo.CPSRI          = cpsr_i;
    assign bus_lo.CPSRF          = cpsr_f;

    assign bus_hi.Stall          = stall;
    assign bus_hi.PrefetchAbortE = pabt;
    assign bus_hi.UndefE         = und;
    assign bus_hi.SWIE           = swi;
    assign bus_hi.DataAbortM     = dabt;
    assign bus_hi.IRQ            = irq;
    assign bus_hi.FIQ            = fiq;
    assign bus_hi.CPSRI          = cpsr_i;
    assign bus_hi.CPSRF          = cpsr_f;

    exception_ctrl #(.HIGH_VECTORS(1'b0), .SYNC_STAGES(2)) dut_lo (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_lo)
    );

    exception_ctrl #(.HIGH_VECTORS(1'b1), .SYNC_STAGES(2)) dut_hi (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_hi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in the SAVE cycle; leaves the bench in the first IDLE cycle.
    task automatic expect_seq(input string tag, input logic [4:0] mode,
                              input logic set_f, input logic [7:0] off);
        chk({tag, ".save"},  32'(bus_lo.ExcSave),  32'd1);
        chk({tag, ".flush"}, 32'(bus_lo.ExcFlush), 32'd1);
        chk({tag, ".mode"},  32'(bus_lo.ExcMode),  32'(mode));
        chk({tag, ".seti"},  32'(bus_lo.ExcSetI),  32'd1);
        chk({tag, ".setf"},  32'(bus_lo.ExcSetF),  32'(set_f));
        chk({tag, ".pcsel0"}, 32'(bus_lo.ExcPCSel), 32'd0);
        chk({tag, ".hsave"}, 32'(bus_hi.ExcSave),  32'd1);
        tick();
        chk({tag, ".pcsel"}, 32'(bus_lo.ExcPCSel), 32'd1);
        chk({tag, ".rflush"}, 32'(bus_lo.ExcFlush), 32'd1);
        chk({tag, ".save0"}, 32'(bus_lo.ExcSave),  32'd0);
        chk({tag, ".vec"},   bus_lo.ExcVector, {24'h0, off});
        chk({tag, ".hvec"},  bus_hi.ExcVector, {24'hFFFF00, off});
        tick();
        chk({tag, ".idle"},  32'(bus_lo.ExcBusy),  32'd0);
        chk({tag, ".pc0"},   32'(bus_lo.ExcPCSel), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        {stall, pabt, und, swi, dabt, irq, fiq, cpsr_i, cpsr_f} = '0;
        #1;
        chk("rst.busy",  32'(bus_lo.ExcBusy),  32'd0);
        chk("rst.flush", 32'(bus_lo.ExcFlush), 32'd0);
        chk("rst.save",  32'(bus_lo.ExcSave),  32'd0);
        chk("rst.vec",   bus_hi.ExcVector,     32'h0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Undefined instruction
        und = 1'b1;
        tick();
        und = 1'b0;
        expect_seq("und", 5'b11011, 1'b0, 8'h04);

        // Data abort beats prefetch abort and undefined
        dabt = 1'b1; pabt = 1'b1; und = 1'b1;
        tick();
        dabt = 1'b0; pabt = 1'b0; und = 1'b0;
        expect_seq("dabt", 5'b10111, 1'b0, 8'h10);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("dabt.nosecond", 32'(bus_lo.ExcBusy), 32'd0);
        end

        // IRQ through the synchroniser
        irq = 1'b1;
        tick();
        chk("irq.sync1", 32'(bus_lo.ExcSave), 32'd0);
        tick();
        chk("irq.sync2", 32'(bus_lo.ExcSave), 32'd0);
        tick();
        irq = 1'b0;
        expect_seq("irq", 5'b10010, 1'b0, 8'h18);

        // Masked IRQ is ignored
        cpsr_i = 1'b1;
        irq = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("irq.masked", 32'(bus_lo.ExcBusy), 32'd0);
        end
        irq = 1'b0;
        repeat (3) tick();
        cpsr_i = 1'b0;

        // FIQ beats IRQ
        fiq = 1'b1; irq = 1'b1;
        repeat (3) tick();
        fiq = 1'b0; irq = 1'b0;
        expect_seq("fiq", 5'b10001, 1'b1, 8'h1C);
        tick();
        chk("fiq.after", 32'(bus_lo.ExcBusy), 32'd0);

        // Stall held across SAVE
        und = 1'b1;
        tick();
        und = 1'b0;
        chk("stall.save0", 32'(bus_lo.ExcSave), 32'd1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall.save", 32'(bus_lo.ExcSave), 32'd1);
            chk("stall.nopc", 32'(bus_lo.ExcPCSel), 32'd0);
        end
        stall = 1'b0;
        tick();
        chk("stall.redir", 32'(bus_lo.ExcPCSel), 32'd1);
        chk("stall.vec",   bus_lo.ExcVector,     32'h04);
        tick();
        chk("stall.idle",  32'(bus_lo.ExcBusy),  32'd0);

        // Reset during REDIRECT, then a clean SWI
        swi = 1'b1;
        tick();
        swi = 1'b0;
        tick();
        chk("rst6.redir", 32'(bus_lo.ExcPCSel), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst6.pc",    32'(bus_lo.ExcPCSel), 32'd0);
        chk("rst6.flush", 32'(bus_lo.ExcFlush), 32'd0);
        chk("rst6.vec",   bus_lo.ExcVector,     32'h0);
        tick();
        reset = 1'b0;
        tick();
        chk("rst6.busy",  32'(bus_lo.ExcBusy),  32'd0);
        chk("rst6.save",  32'(bus_lo.ExcSave),  32'd0);
        swi = 1'b1;
        tick();
        swi = 1'b0;
        expect_seq("swi", 5'b10011, 1'b0, 8'h08);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
